dcache_dm_wt: RTL and testbench
===============================

Name: dcache_dm_wt

Overview:
- Parametrised, direct-mapped, write-through, no-write-allocate data cache.
- Sits between the core's load/store stage and a slower word-wide backing data memory.
- Replaces the flat single-cycle data memory with handshaked core and memory ports, byte enables, flush, and hit/miss counters.
- Line size is one word.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: word width; must be a multiple of 8.
- LINES, 16: number of cache lines; must be a power of two, ≥2.
- CNT_W, 32: width of the hit and miss counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  cache can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; low OFF_W bits ignored.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  store byte enables.
- resp_valid  out  1  one-cycle pulse: load data or store ack.
- resp_rdata  out  DATA_W  load data, valid with resp_valid.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  backing memory request valid.
- mem_req_ready  in  1  backing memory accepts request.
- mem_req_we  out  1  backing write.
- mem_req_addr  out  ADDR_W  word-aligned address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_be  out  DATA_W/8  write byte enables.
- mem_resp_valid  in  1  read data or write ack returned.
- mem_resp_rdata  in  DATA_W  read data.
- hit_cnt  out  CNT_W  saturating hit counter.
- miss_cnt  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all valid bits cleared; counters = 0.
  - resp_valid = 0, resp_rdata = 0, mem_req_valid = 0, mem_req_* = 0.
  - Data and tag arrays are not reset.
- Address split: OFF_W = log2(DATA_W/8); index = addr[OFF_W +: IDX_W]; tag = upper TAG_W bits.
- req_ready = 1 only in IDLE with flush = 0.
- A request is accepted on req_valid & req_ready and latched; the FSM moves to LOOKUP.
- IDLE with flush = 1: all valid bits clear that cycle; no request is accepted; the FSM stays in IDLE.
- LOOKUP, load hit:
  - resp_valid = 1 with line data; hit_cnt += 1; next state IDLE.
  - Latency: accept at cycle N, response at N+1.
- LOOKUP, load miss: miss_cnt += 1; next state RD_REQ.
- LOOKUP, store hit:
  - Merge the enabled bytes into the line; hit_cnt += 1; next state WR_REQ.
- LOOKUP, store miss: miss_cnt += 1; no allocation; next state WR_REQ.
- RD_REQ:
  - mem_req_valid = 1, mem_req_we = 0, address word-aligned.
  - Hold all mem_req_* stable until mem_req_ready; then go to RD_WAIT.
- RD_WAIT:
  - On mem_resp_valid, write the line data, tag and valid = 1.
  - resp_valid = 1 with mem_resp_rdata, same cycle; next state IDLE.
- WR_REQ: as RD_REQ but with mem_req_we = 1 and req_be forwarded; on mem_req_ready go to WR_WAIT.
- WR_WAIT: on mem_resp_valid, resp_valid = 1 as store ack (resp_rdata = 0); next state IDLE.
- mem_resp_valid outside the WAIT states is ignored.
- A store with req_be = 0 still performs the full transaction and counts as a hit or miss.
- Counters saturate at all-ones.
- flush outside IDLE is ignored; the core must hold it until req_ready = 1.
- Reset mid-transaction:
  - The transaction is abandoned and no response is issued.
  - The backing memory shares rst_n, so no transaction is outstanding after release.
- One outstanding request at a time. resp_valid never asserts in the cycle after reset release.

Decomposition:
- Package dcache_pkg:
  - State enum: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - Localparam functions for OFF_W, IDX_W and TAG_W from ADDR_W, DATA_W and LINES.
- Sub-module dcache_line_store:
  - Holds the valid, tag and data arrays.
  - Combinational read by index; synchronous write with byte merge; single-cycle clear-all of the valid bits.
- The top level holds the FSM, request latch and counters.

Test Plan:
- Reset, then load 0x40 with memory holding 0xDEADBEEF there → one mem read to 0x40; resp_rdata = 0xDEADBEEF; miss_cnt = 1. Repeat load → response one cycle after accept, no mem_req_valid, hit_cnt = 1.
- Store 0x40, wdata 0x000000AA, be 0b0001 after the fill → mem write, be 0b0001; store ack. Then load 0x40 → hit, returns 0xDEADBEAA.
- Store to uncached 0x80 → mem write only. Then load 0x80 → miss (no allocate).
- Conflict: fill 0x40, then load 0x40 + LINES*4 → miss and refill. Then load 0x40 → miss again.
- mem_req_ready held low 5 cycles in RD_REQ → mem_req_* stable throughout; resp_valid only after mem_resp_valid. Also: flush and req_valid together in IDLE → req_ready = 0, all lines invalid; the next load to 0x40 misses.
- rst_n pulsed low during RD_WAIT → outputs return to reset values immediately; no resp_valid afterward; counters = 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int lines);
    return addr_w - off_w(data_w) - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read by index, byte-merging write, one-cycle invalidate-all.
module dcache_line_store #(
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_all,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_be[b]) data_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// state   | meaning
// IDLE    | ready for a request; flush invalidates all lines
// LOOKUP  | tag compare on the latched request
// RD_REQ  | read miss: backing read presented, waiting for mem_req_ready
// RD_WAIT | waiting for read data; fills the line and responds
// WR_REQ  | store: backing write presented, waiting for mem_req_ready
// WR_WAIT | waiting for write ack; responds with store ack
module dcache_dm_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_be,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_wdata,
  output logic [DATA_W/8-1:0]  mem_req_be,
  input  logic                 mem_resp_valid,
  input  logic [DATA_W-1:0]    mem_resp_rdata,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int OFF_W = off_w(DATA_W);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, DATA_W, LINES);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  state_t              state;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [DATA_W-1:0]   line_data;
  logic                hit;
  logic                fill;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [BE_W-1:0]     wr_be;

  assign idx       = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign hit       = line_valid && (line_tag == tag);
  assign req_ready = (state == IDLE) && !flush;

  // One write port serves both the store-hit merge and the miss fill (all bytes).
  assign fill    = (state == RD_WAIT) && mem_resp_valid;
  assign wr_en   = fill || ((state == LOOKUP) && we_q && hit);
  assign wr_data = fill ? mem_resp_rdata : wdata_q;
  assign wr_be   = fill ? {BE_W{1'b1}} : be_q;

  dcache_line_store #(
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_line_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all ((state == IDLE) && flush),
    .rd_idx    (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_idx    (idx),
    .wr_tag    (tag),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) hit_cnt  <= sat_inc(hit_cnt);
          else     miss_cnt <= sat_inc(miss_cnt);
          if (!we_q && hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= line_data;
            state      <= IDLE;
          end else begin
            // Stores always go through to memory; load misses fetch the word.
            mem_req_valid <= 1'b1;
            mem_req_we    <= we_q;
            mem_req_addr  <= addr_q & ALIGN_MASK;
            mem_req_wdata <= we_q ? wdata_q : '0;
            mem_req_be    <= we_q ? be_q : '0;
            state         <= we_q ? WR_REQ : RD_REQ;
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RD_WAIT;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= mem_resp_rdata;
            state      <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed plus randomized bench for dcache_dm_wt against a line-level cache/memory reference model.
module tb_dcache_dm_wt;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_be;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  always #5 clk = ~clk;

  dcache_dm_wt #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // bmem is the backing memory the DUT talks to; ref_mem is the model's view of it.
  logic [31:0] bmem    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  bit          m_valid [LINES];
  logic [25:0] m_tag   [LINES];
  int          m_hits;
  int          m_misses;

  logic [31:0] r_rdata, r_maddr, r_mwdata;
  logic [3:0]  r_mbe;
  logic        r_mwe;
  bit          r_resp, r_mem, r_stable, r_early, r_ready_at_req;
  int          r_lat;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [29:0] wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Presents one request at a negedge and plays the backing memory until the response arrives.
  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall);
    int stall_left;
    bit handshook, resp_due, resp_sent;
    stall_left = stall;
    handshook = 0; resp_due = 0; resp_sent = 0;
    r_resp = 0; r_mem = 0; r_stable = 1; r_early = 0; r_lat = -1;
    r_rdata = '0; r_maddr = '0; r_mwdata = '0; r_mbe = '0; r_mwe = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    #1 r_ready_at_req = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    for (int c = 1; c <= 60 && !r_resp; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      if (handshook && mem_req_valid) r_stable = 0;
      if (resp_valid) begin
        r_resp  = 1;
        r_rdata = resp_rdata;
        r_lat   = c;
        r_early = r_mem && !resp_sent;
      end else if (resp_due) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = r_mwe ? $urandom : bmem_rd(r_maddr[31:2]);
        if (r_mwe) bmem[r_maddr[31:2]] = merge(bmem_rd(r_maddr[31:2]), r_mwdata, r_mbe);
        resp_due  = 0;
        resp_sent = 1;
      end else if (mem_req_valid && !handshook) begin
        if (!r_mem) begin
          r_mem = 1; r_mwe = mem_req_we; r_maddr = mem_req_addr;
          r_mwdata = mem_req_wdata; r_mbe = mem_req_be;
        end else if (mem_req_we !== r_mwe || mem_req_addr !== r_maddr ||
                     (r_mwe && (mem_req_wdata !== r_mwdata || mem_req_be !== r_mbe))) begin
          r_stable = 0;
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          handshook = 1;
          resp_due  = 1;
        end
      end
    end
  endtask

  task automatic do_op(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [29:0] wa;
    logic [31:0] exp_rdata;
    bit          hit;
    idx = addr[5:2]; tg = addr[31:6]; wa = addr[31:2];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) m_hits = sat(m_hits);
    else     m_misses = sat(m_misses);
    if (!we) begin
      exp_rdata = ref_rd(wa);
      if (!hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
    end else begin
      exp_rdata = '0;
      ref_mem[wa] = merge(ref_rd(wa), wdata, be);
    end
    run(we, addr, wdata, be, stall);
    chk({tag, "_ready"}, r_ready_at_req, 1);
    chk({tag, "_resp"}, r_resp, 1);
    chk({tag, "_rdata"}, r_rdata, exp_rdata);
    chk({tag, "_mem_used"}, r_mem, (we || !hit));
    if (r_mem) begin
      chk({tag, "_mem_we"}, r_mwe, we);
      chk({tag, "_mem_addr"}, r_maddr, {wa, 2'b00});
      if (we) begin
        chk({tag, "_mem_be"}, r_mbe, be);
        chk({tag, "_mem_wdata"}, r_mwdata, wdata);
      end
      chk({tag, "_mem_stable"}, r_stable, 1);
      chk({tag, "_early_resp"}, r_early, 0);
    end
    if (!we && hit) chk({tag, "_hit_latency"}, r_lat, 1);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, resp_valid, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, m_hits);
    chk({tag, "_miss_cnt"}, miss_cnt, m_misses);
  endtask

  task automatic do_flush(input bit with_req);
    flush = 1'b1; req_valid = with_req; req_we = 1'b0; req_addr = $urandom;
    #1 chk("flush_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", {mem_req_valid, resp_valid}, 0);
    chk("flush_hit_cnt", hit_cnt, m_hits);
    chk("flush_miss_cnt", miss_cnt, m_misses);
  endtask

  initial begin
    bit seen;
    int nresp;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata[27:0], mem_req_be}, 0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_resp", resp_valid, 0);

    bmem[30'h10]    = 32'hDEAD_BEEF;
    ref_mem[30'h10] = 32'hDEAD_BEEF;
    do_op("ld40_miss", 1'b0, 32'h40, '0, '0, 0);
    chk("ld40_value", r_rdata, 32'hDEAD_BEEF);
    chk("ld40_miss_cnt1", miss_cnt, 1);
    do_op("ld40_hit", 1'b0, 32'h40, '0, '0, 0);
    chk("ld40_hit_cnt1", hit_cnt, 1);
    do_op("st40_b0", 1'b1, 32'h40, 32'h0000_00AA, 4'b0001, 0);
    do_op("ld40_merged", 1'b0, 32'h40, '0, '0, 0);
    chk("ld40_merged_value", r_rdata, 32'hDEAD_BEAA);

    do_op("st80_nowa", 1'b1, 32'h80, 32'h1234_5678, 4'b1111, 1);
    do_op("ld80_miss", 1'b0, 32'h80, '0, '0, 0);
    do_op("conf_ld40", 1'b0, 32'h40, '0, '0, 0);
    do_op("conf_ld40p", 1'b0, 32'h40 + LINES * 4, '0, '0, 0);
    do_op("conf_ld40_again", 1'b0, 32'h40, '0, '0, 0);
    do_op("st_be0", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 0);

    do_op("stall_ld", 1'b0, 32'h1C4, '0, '0, 5);
    do_op("stall_st", 1'b1, 32'h1C6, 32'hCAFE_0001, 4'b1010, 5);

    do_flush(1'b1);
    do_op("post_flush_ld40", 1'b0, 32'h40, '0, '0, 0);

    // Reset while the cache is waiting for read data.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2C0;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_req_valid) begin seen = 1; mem_req_ready = 1'b1; end
    end
    chk("rstmid_mem_req", seen, 1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_mem_req_valid", mem_req_valid, 0);
    chk("rstmid_mem_req_addr", mem_req_addr, 0);
    chk("rstmid_counters", {hit_cnt, miss_cnt}, 0);
    chk("rstmid_req_ready", req_ready, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
    nresp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (resp_valid) nresp++;
    end
    chk("rstmid_no_resp", nresp, 0);
    chk("rstmid_counters_after", {hit_cnt, miss_cnt}, 0);
    do_op("rstmid_ld40_cold", 1'b0, 32'h40, '0, '0, 0);

    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, LINES - 1)) << 2) |
          32'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) do_flush(1'($urandom_range(0, 1)));
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 2) == 0), a, $urandom,
            4'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
